mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter: read-owner encoding and the
// default DM streak limit.
package riscv_pkg;

   typedef enum logic [1:0] {
      OwnerNone = 2'd0,
      OwnerIf   = 2'd1,
      OwnerDm   = 2'd2
   } owner_e;

   localparam int unsigned MAX_DM_STREAK_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-ported memory with
// one-cycle read latency and a bounded DM streak so fetch cannot starve.
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int unsigned MAX_DM_STREAK = MAX_DM_STREAK_DEFAULT,
   parameter int unsigned ADDR_W        = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   input  logic [3:0]        dm_mask,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [31:0]       dm_rdata,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_mask,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned            StreakW   = $clog2(MAX_DM_STREAK + 1);
   localparam logic [StreakW-1:0]     StreakMax = StreakW'(MAX_DM_STREAK);

   owner_e               owner_q, owner_d;
   logic [StreakW-1:0]   streak_q, streak_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q  <= OwnerNone;
         streak_q <= '0;
      end else begin
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   always_comb begin
      dm_gnt    = 1'b0;
      if_gnt    = 1'b0;
      owner_d   = OwnerNone;
      streak_d  = streak_q;
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_mask  = 4'h0;

      // Grants are gated by reset so nothing reaches memory while held in reset.
      dm_gnt = reset & dm_req & (~if_req | (streak_q < StreakMax));
      if_gnt = reset & if_req & ~dm_gnt;

      if (!if_req || if_gnt) begin
         streak_d = '0;
      end else if (dm_gnt && (streak_q != StreakMax)) begin
         streak_d = streak_q + 1'b1;
      end

      if (if_gnt) begin
         owner_d  = OwnerIf;
         mem_cs   = 1'b1;
         mem_addr = if_addr;
         mem_mask = 4'hF;
      end else if (dm_gnt) begin
         owner_d   = dm_we ? OwnerNone : OwnerDm;
         mem_cs    = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
         mem_mask  = dm_mask;
      end
   end

   always_comb begin
      if_rvalid = (owner_q == OwnerIf);
      dm_rvalid = (owner_q == OwnerDm);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      dm_rdata  = dm_rvalid ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant checks per cycle plus a scoreboard
// of issued reads whose data is returned and checked on the following cycle.
module tb_mem_arbiter;
   import riscv_pkg::*;

   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rvalid;
   logic [31:0]   if_rdata;
   logic          dm_req, dm_we;
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_wdata;
   logic [3:0]    dm_mask;
   logic          dm_gnt, dm_rvalid;
   logic [31:0]   dm_rdata;
   logic          mem_cs, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_mask;
   logic [31:0]   mem_rdata;

   typedef struct {
      owner_e      who;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MAX_DM_STREAK(4), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_mask   (dm_mask),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_mask  (mem_mask),
      .mem_rdata (mem_rdata)
   );

   // Advance to just after the next rising edge and present read data for any
   // read issued in the previous cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
      mem_rdata = (sb.size() > 0) ? sb[0].data : $urandom;
   endtask

   task automatic test_reset();
      reset = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
      if_addr = 32'h4; dm_addr = 32'h8; dm_wdata = 32'hA5A5A5A5; dm_mask = 4'hF;
      mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      tests++;
      if ({if_gnt, dm_gnt} !== 2'b00) begin
         fails++; $display("FAIL reset_grants: got %b want 00", {if_gnt, dm_gnt});
      end
      tests++;
      if ({if_rvalid, dm_rvalid, mem_cs} !== 3'b000 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_outputs: got rv=%b%b cs=%b ifd=%h dmd=%h want 0", if_rvalid,
                  dm_rvalid, mem_cs, if_rdata, dm_rdata);
      end
      cyc();
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if ({if_gnt, dm_gnt} !== 2'b01 || mem_we !== 1'b1) begin
         fails++;
         $display("FAIL first_grant_after_release: got if/dm=%b we=%b want 01 we=1",
                  {if_gnt, dm_gnt}, mem_we);
      end
      cyc();
      if_req = 1'b0; dm_req = 1'b0;
      @(negedge clk);
      tests++;
      if ({if_rvalid, dm_rvalid} !== 2'b00) begin
         fails++; $display("FAIL store_after_reset_rvalid: got %b want 00", {if_rvalid, dm_rvalid});
      end
   endtask

   task automatic test_single_if();
      exp_t e;
      cyc();
      if_req = 1'b1; if_addr = 32'h10;
      @(negedge clk);
      tests++;
      if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || mem_cs !== 1'b1 || mem_addr !== 32'h10 ||
          mem_we !== 1'b0 || mem_mask !== 4'hF || mem_wdata !== 32'h0) begin
         fails++;
         $display("FAIL if_grant: got gnt=%b cs=%b addr=%h we=%b mask=%h wd=%h want 1 1 10 0 f 0",
                  if_gnt, mem_cs, mem_addr, mem_we, mem_mask, mem_wdata);
      end
      sb.push_back('{who: OwnerIf, data: 32'hDEADBEEF});
      cyc();
      if_req = 1'b0;
      e = sb.pop_front();
      @(negedge clk);
      tests++;
      if (if_rvalid !== 1'b1 || if_rdata !== e.data || dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin
         fails++;
         $display("FAIL if_read_data: got rv=%b d=%h dmrv=%b dmd=%h want 1 %h 0 0", if_rvalid,
                  if_rdata, dm_rvalid, dm_rdata, e.data);
      end
   endtask

   task automatic test_collision();
      exp_t e;
      cyc();
      if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
      @(negedge clk);
      tests++;
      if ({if_gnt, dm_gnt} !== 2'b01 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin
         fails++;
         $display("FAIL collision_dm_wins: got if/dm=%b addr=%h want 01 200", {if_gnt, dm_gnt},
                  mem_addr);
      end
      sb.push_back('{who: OwnerDm, data: 32'h0BADF00D});
      cyc();
      dm_req = 1'b0;
      e = sb.pop_front();
      @(negedge clk);
      tests++;
      if ({if_gnt, dm_gnt} !== 2'b10 || mem_addr !== 32'h20) begin
         fails++;
         $display("FAIL collision_if_next: got if/dm=%b addr=%h want 10 20", {if_gnt, dm_gnt},
                  mem_addr);
      end
      tests++;
      if (dm_rvalid !== 1'b1 || dm_rdata !== e.data || if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
         fails++;
         $display("FAIL collision_dm_data: got rv=%b d=%h ifrv=%b want 1 %h 0", dm_rvalid,
                  dm_rdata, if_rvalid, e.data);
      end
      sb.push_back('{who: OwnerIf, data: 32'h13572468});
      cyc();
      if_req = 1'b0;
      e = sb.pop_front();
      @(negedge clk);
      tests++;
      if (if_rvalid !== 1'b1 || if_rdata !== e.data || dm_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL collision_if_data: got rv=%b d=%h want 1 %h", if_rvalid, if_rdata, e.data);
      end
   endtask

   // Both ports held for 10 cycles: DM wins four in a row, then IF once.
   task automatic test_starvation();
      exp_t e;
      logic exp_if;
      for (int i = 0; i <= 10; i++) begin
         cyc();
         if (i < 10) begin
            if_req = 1'b1; if_addr = 32'h100 + 32'(i); dm_req = 1'b1; dm_we = 1'b0;
            dm_addr = 32'h800 + 32'(i);
         end else begin
            if_req = 1'b0; dm_req = 1'b0;
         end
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (if_rvalid !== (e.who == OwnerIf) || dm_rvalid !== (e.who == OwnerDm) ||
                (e.who == OwnerIf && if_rdata !== e.data) ||
                (e.who == OwnerDm && dm_rdata !== e.data)) begin
               fails++;
               $display("FAIL starve_rdata[%0d]: got rv=%b%b ifd=%h dmd=%h want owner=%s d=%h", i,
                        if_rvalid, dm_rvalid, if_rdata, dm_rdata, e.who.name(), e.data);
            end
         end
         if (i < 10) begin
            exp_if = (i == 4) || (i == 9);
            tests++;
            if (if_gnt !== exp_if || dm_gnt !== !exp_if) begin
               fails++;
               $display("FAIL starve_grant[%0d]: got if/dm=%b%b want %b%b", i, if_gnt, dm_gnt,
                        exp_if, !exp_if);
            end
            sb.push_back('{who: exp_if ? OwnerIf : OwnerDm, data: $urandom});
         end
      end
   endtask

   task automatic test_store();
      cyc();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678; dm_mask = 4'b0011;
      @(negedge clk);
      tests++;
      if (dm_gnt !== 1'b1 || mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 ||
          mem_wdata !== 32'h12345678 || mem_mask !== 4'b0011) begin
         fails++;
         $display("FAIL store_issue: got gnt=%b cs=%b we=%b a=%h wd=%h m=%b want 1 1 1 40 12345678 0011",
                  dm_gnt, mem_cs, mem_we, mem_addr, mem_wdata, mem_mask);
      end
      cyc();
      dm_req = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      tests++;
      if ({if_rvalid, dm_rvalid} !== 2'b00 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
         fails++;
         $display("FAIL store_no_rvalid: got rv=%b%b ifd=%h dmd=%h want 0", if_rvalid, dm_rvalid,
                  if_rdata, dm_rdata);
      end
      tests++;
      if ({mem_cs, mem_we} !== 2'b00 || mem_addr !== '0 || mem_wdata !== 32'h0 || mem_mask !== 4'h0) begin
         fails++;
         $display("FAIL idle_mem: got cs=%b we=%b a=%h wd=%h m=%h want all 0", mem_cs, mem_we,
                  mem_addr, mem_wdata, mem_mask);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      cyc();
      if_req = 1'b1; if_addr = 32'h30;
      @(negedge clk);
      sb.push_back('{who: OwnerIf, data: 32'hCAFE0001});
      cyc();
      if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
      e = sb.pop_front();
      @(negedge clk);
      tests++;
      if (if_rvalid !== 1'b1 || if_rdata !== e.data || dm_gnt !== 1'b1 || mem_addr !== 32'h300) begin
         fails++;
         $display("FAIL pipe_if_then_dm: got rv=%b d=%h dmgnt=%b a=%h want 1 %h 1 300", if_rvalid,
                  if_rdata, dm_gnt, mem_addr, e.data);
      end
      sb.push_back('{who: OwnerDm, data: 32'hCAFE0002});
      cyc();
      dm_req = 1'b0;
      e = sb.pop_front();
      @(negedge clk);
      tests++;
      if (dm_rvalid !== 1'b1 || dm_rdata !== e.data || if_rvalid !== 1'b0) begin
         fails++;
         $display("FAIL pipe_dm_data: got rv=%b d=%h ifrv=%b want 1 %h 0", dm_rvalid, dm_rdata,
                  if_rvalid, e.data);
      end
   endtask

   task automatic test_reset_mid_read();
      // Read registered, then reset asserted mid-cycle: rvalid must drop at once.
      cyc();
      if_req = 1'b1; if_addr = 32'h50;
      cyc();
      if_req = 1'b0;
      #2;
      tests++;
      if (if_rvalid !== 1'b1) begin
         fails++; $display("FAIL midread_pre: got rv=%b want 1", if_rvalid);
      end
      reset = 1'b0;
      #1;
      tests++;
      if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
         fails++; $display("FAIL midread_async_clear: got rv=%b d=%h want 0 0", if_rvalid, if_rdata);
      end
      cyc();
      reset = 1'b1;
      // Grant in the cycle just before reset: must not surface after release.
      cyc();
      if_req = 1'b1; if_addr = 32'h54;
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if ({if_gnt, if_rvalid, mem_cs} !== 3'b000) begin
         fails++;
         $display("FAIL reset_gates_grant: got gnt=%b rv=%b cs=%b want 000", if_gnt, if_rvalid, mem_cs);
      end
      cyc();
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (if_rvalid !== 1'b0 || if_gnt !== 1'b1) begin
         fails++;
         $display("FAIL release_no_stale_rvalid: got rv=%b gnt=%b want 0 1", if_rvalid, if_gnt);
      end
      sb.push_back('{who: OwnerIf, data: 32'h55AA55AA});
      cyc();
      if_req = 1'b0;
      begin
         exp_t e;
         e = sb.pop_front();
         @(negedge clk);
         tests++;
         if (if_rvalid !== 1'b1 || if_rdata !== e.data) begin
            fails++;
            $display("FAIL release_read_data: got rv=%b d=%h want 1 %h", if_rvalid, if_rdata, e.data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_if();
      test_collision();
      test_starvation();
      test_store();
      test_back_to_back();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
